// File: rtl/mcc_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// ALU operation codes (also consumed by the ALU) and the control bus.
package mcc_pkg;

  localparam int OPC_W   = 6;
  localparam int STATE_W = 3;

  localparam logic [OPC_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPC_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b010000;
  localparam logic [OPC_W-1:0] OP_AND   = 6'b010001;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [OPC_W-1:0] OP_OR    = 6'b010011;
  localparam logic [OPC_W-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'b011100;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b100110;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100111;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b110101;
  localparam logic [OPC_W-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [OPC_W-1:0] OP_J     = 6'b111000;
  localparam logic [OPC_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'b111010;
  localparam logic [OPC_W-1:0] OP_HALT  = 6'b111111;

  typedef enum logic [STATE_W-1:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_AND  = 3'b100,
    ALU_SLTU = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_XOR  = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       alu_src_a;
    logic       alu_src_b;
    alu_op_t    alu_op;
    logic       ext_sel;
    logic       m_rd;
    logic       m_wr;
    logic       reg_wre;
    logic [1:0] reg_dst;
    logic       wr_reg_d_src;
    logic       db_data_src;
    logic [1:0] pc_src;
  } ctrl_t;

  // Opcodes that legitimately write the register file at sWB_AL.
  function automatic logic is_alu_wr(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_ANDI, OP_AND,
      OP_ORI, OP_OR, OP_SLL, OP_SLTI: is_alu_wr = 1'b1;
      default:                        is_alu_wr = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcc_decode.sv
// Combinational control decode: (state, opcode, zero, sign) -> control bus.
// Selects follow the opcode in every state; enables and PCSrc follow the state.
module mcc_decode
  import mcc_pkg::*;
(
  input  state_t           state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             sign,
  output ctrl_t            ctl
);

  logic br_taken;

  assign br_taken = ((opcode == OP_BEQ)  &&  zero) ||
                    ((opcode == OP_BNE)  && !zero) ||
                    ((opcode == OP_BLTZ) &&  sign);

  always_comb begin
    ctl              = '0;
    ctl.alu_op       = ALU_ADD;
    ctl.wr_reg_d_src = 1'b1;

    case (opcode)
      OP_ADD:   ctl.reg_dst = 2'b10;
      OP_SUB:   begin ctl.alu_op = ALU_SUB; ctl.reg_dst = 2'b10; end
      OP_ADDIU: begin ctl.alu_src_b = 1'b1; ctl.ext_sel = 1'b1; ctl.reg_dst = 2'b01; end
      OP_ANDI:  begin ctl.alu_op = ALU_AND; ctl.alu_src_b = 1'b1; ctl.reg_dst = 2'b01; end
      OP_AND:   begin ctl.alu_op = ALU_AND; ctl.reg_dst = 2'b10; end
      OP_ORI:   begin ctl.alu_op = ALU_OR;  ctl.alu_src_b = 1'b1; ctl.reg_dst = 2'b01; end
      OP_OR:    begin ctl.alu_op = ALU_OR;  ctl.reg_dst = 2'b10; end
      OP_SLL:   begin ctl.alu_op = ALU_SLL; ctl.alu_src_a = 1'b1; ctl.reg_dst = 2'b10; end
      OP_SLTI:  begin
        ctl.alu_op    = ALU_SLT;
        ctl.alu_src_b = 1'b1;
        ctl.ext_sel   = 1'b1;
        ctl.reg_dst   = 2'b01;
      end
      OP_SW:    begin ctl.alu_src_b = 1'b1; ctl.ext_sel = 1'b1; end
      OP_LW:    begin
        ctl.alu_src_b   = 1'b1;
        ctl.ext_sel     = 1'b1;
        ctl.reg_dst     = 2'b01;
        ctl.db_data_src = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLTZ: begin ctl.alu_op = ALU_SUB; ctl.ext_sel = 1'b1; end
      OP_JAL:   begin ctl.reg_dst = 2'b00; ctl.wr_reg_d_src = 1'b0; end
      default:  ;
    endcase

    case (state)
      S_IF: ctl.ir_wre = 1'b1;
      S_ID: begin
        case (opcode)
          OP_J:   begin ctl.pc_wre = 1'b1; ctl.pc_src = 2'b11; end
          OP_JR:  begin ctl.pc_wre = 1'b1; ctl.pc_src = 2'b10; end
          OP_JAL: begin ctl.pc_wre = 1'b1; ctl.pc_src = 2'b11; ctl.reg_wre = 1'b1; end
          default: ;
        endcase
      end
      S_EXE_BR: begin
        ctl.pc_wre = 1'b1;
        ctl.pc_src = br_taken ? 2'b01 : 2'b00;
      end
      S_MEM: begin
        ctl.m_rd   = (opcode == OP_LW);
        ctl.m_wr   = (opcode == OP_SW);
        ctl.pc_wre = (opcode == OP_SW);
      end
      S_WB_AL: begin
        ctl.pc_wre  = 1'b1;
        ctl.reg_wre = is_alu_wr(opcode);
      end
      S_WB_LD: begin ctl.pc_wre = 1'b1; ctl.reg_wre = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: state/halt flops around mcc_decode.
// Define MCC_PERF_CNT_EN to add the cyc_cnt/inst_cnt performance counters.
module multi_cycle_ctrl
  import mcc_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            sign,
  output logic            PCWre,
  output logic            IRWre,
  output logic            ALUSrcA,
  output logic            ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic            ExtSel,
  output logic            mRD,
  output logic            mWR,
  output logic            RegWre,
  output logic [1:0]      RegDst,
  output logic            WrRegDSrc,
  output logic            DBDataSrc,
  output logic [1:0]      PCSrc,
  output logic [ST_W-1:0] state
`ifdef MCC_PERF_CNT_EN
  ,
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     inst_cnt
`endif
);

  state_t           cur, nxt;
  logic             halted;
  logic [OPC_W-1:0] op;
  ctrl_t            dec, ctl;

  assign op = opcode;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cur    <= S_IF;
      halted <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_ID && op == OP_HALT) halted <= 1'b1;
    end
  end

  // Halt parks the register in sIF; the halted flop is what freezes it.
  always_comb begin
    nxt = cur;
    if (!halted) begin
      case (cur)
        S_IF: nxt = S_ID;
        S_ID: begin
          case (op)
            OP_J, OP_JAL, OP_JR, OP_HALT: nxt = S_IF;
            OP_BEQ, OP_BNE, OP_BLTZ:      nxt = S_EXE_BR;
            OP_LW, OP_SW:                 nxt = S_EXE_LS;
            default:                      nxt = S_EXE_AL;
          endcase
        end
        S_EXE_AL: nxt = S_WB_AL;
        S_WB_AL:  nxt = S_IF;
        S_EXE_BR: nxt = S_IF;
        S_EXE_LS: nxt = S_MEM;
        S_MEM:    nxt = (op == OP_LW) ? S_WB_LD : S_IF;
        S_WB_LD:  nxt = S_IF;
      endcase
    end
  end

  mcc_decode u_decode (
    .state  (cur),
    .opcode (op),
    .zero   (zero),
    .sign   (sign),
    .ctl    (dec)
  );

  // Reset clears the whole bus so a mid-instruction RST leaves no partial write.
  always_comb begin
    ctl = dec;
    if (halted) begin
      ctl.pc_wre  = 1'b0;
      ctl.ir_wre  = 1'b0;
      ctl.reg_wre = 1'b0;
      ctl.m_rd    = 1'b0;
      ctl.m_wr    = 1'b0;
    end
    if (RST) ctl = '0;
  end

  assign PCWre     = ctl.pc_wre;
  assign IRWre     = ctl.ir_wre;
  assign ALUSrcA   = ctl.alu_src_a;
  assign ALUSrcB   = ctl.alu_src_b;
  assign ALUOp     = ctl.alu_op;
  assign ExtSel    = ctl.ext_sel;
  assign mRD       = ctl.m_rd;
  assign mWR       = ctl.m_wr;
  assign RegWre    = ctl.reg_wre;
  assign RegDst    = ctl.reg_dst;
  assign WrRegDSrc = ctl.wr_reg_d_src;
  assign DBDataSrc = ctl.db_data_src;
  assign PCSrc     = ctl.pc_src;
  assign state     = RST ? S_IF : cur;

`ifdef MCC_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      if (!halted)    cyc_cnt  <= cyc_cnt + 32'd1;
      if (ctl.pc_wre) inst_cnt <= inst_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle MIPS-subset control unit, directly upstream of the ALU.
- Sequences each instruction through IF/ID/EXE/MEM/WB and drives ALUOp (3-bit encoding: ADD=000, SUB=001, SLL=010, OR=011, AND=100, SLTU=101, SLT=110, XOR=111).
- Drives the datapath mux selects and write enables.
- Consumes the ALU zero/sign flags to resolve branches.

Parameters:
- OP_W, 6, opcode width.
- ST_W, 3, state register width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26] of the latched instruction.
- zero  in  1  ALU result==0.
- sign  in  1  ALU result[31].
- PCWre  out  1  PC write enable.
- IRWre  out  1  instruction register write enable.
- ALUSrcA  out  1  0=rs data, 1=sa (shamt).
- ALUSrcB  out  1  0=rt data, 1=extended immediate.
- ALUOp  out  3  ALU operation code.
- ExtSel  out  1  0=zero-extend, 1=sign-extend.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- RegWre  out  1  register file write enable.
- RegDst  out  2  00=$31, 01=rt, 10=rd.
- WrRegDSrc  out  1  0=PC+4 (jal), 1=ALU/memory data.
- DBDataSrc  out  1  0=ALU result, 1=memory data.
- PCSrc  out  2  00=PC+4, 01=branch target, 10=jr (rs), 11=jump target.
- state  out  3  current state, for debug.

Behaviour:
- One clock domain, reset is synchronous and active-high: clock CLK, reset RST.
- States: sIF=000, sID=001, sEXE_AL=110, sEXE_BR=101, sEXE_LS=010, sMEM=011, sWB_AL=111, sWB_LD=100, sHALT.
  - ST_W is 3 bits, so sHALT cannot be a ninth distinct encoding. sHALT is signalled by a separate halted flop; `state` keeps reading sIF while halted.
- Opcodes:
  - add=000000, sub=000001, addiu=000010, andi=010000, and=010001, ori=010010, or=010011
  - sll=011000, slti=011100, sw=100110, lw=100111
  - beq=110100, bne=110101, bltz=110110
  - j=111000, jr=111001, jal=111010, halt=111111
- Transitions:
  - sIF -> sID always.
  - sID:
    - j/jal/jr -> sIF.
    - halt -> sHALT (sticky until RST).
    - beq/bne/bltz -> sEXE_BR.
    - lw/sw -> sEXE_LS.
    - Everything else -> sEXE_AL.
  - sEXE_AL -> sWB_AL -> sIF.
  - sEXE_BR -> sIF.
  - sEXE_LS -> sMEM.
  - sMEM: lw -> sWB_LD -> sIF; sw -> sIF.
  - Unknown opcode: treated as a nop. Path sEXE_AL -> sWB_AL with RegWre=0.
- Outputs are combinational from registered state and opcode.
- Enable outputs:
  - IRWre=1 only in sIF.
  - PCWre=1 in the last state of every instruction: sID for jumps, sEXE_BR, sWB_AL, sWB_LD, sMEM for sw. Never asserted in sHALT.
  - RegWre=1 only in sWB_AL/sWB_LD, or in sID for jal.
  - mWR=1 only in sMEM for sw; mRD=1 only in sMEM for lw.
- Branch resolution, evaluated in sEXE_BR with ALUOp=SUB:
  - PCSrc=01 if (beq & zero) | (bne & ~zero) | (bltz & sign).
  - Otherwise PCSrc=00.
- ALUOp mapping:
  - add/addiu/lw/sw -> ADD.
  - sub/beq/bne/bltz -> SUB.
  - sll -> SLL (ALUSrcA=1).
  - ori/or -> OR.
  - and/andi -> AND.
  - slti -> SLT.
- ExtSel=1 for addiu/slti/lw/sw/branches; 0 for andi/ori.
- ALUOp, PCSrc and RegDst hold their values from sEXE through sWB, since opcode is stable between IRWre pulses.
- Reset:
  - While RST=1, all enables (PCWre, IRWre, RegWre, mRD, mWR) are forced to 0.
  - Selects are forced to 0; state=sIF.
  - On the first clock after RST deasserts, the unit is in sIF with IRWre=1.
  - RST mid-instruction aborts it, with no partial write.

Optional Feature:
- Macro MCC_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - cyc_cnt [31:0]: increments every non-reset, non-halt cycle.
  - inst_cnt [31:0]: increments when PCWre=1.
  - Both clear on RST and wrap at 2^32.
- When undefined, the ports and registers are absent.

Decomposition:
- Package mcc_pkg holds:
  - The opcode localparams.
  - The state encodings.
  - The ALUOp codes, shared with the ALU.
- One sub-module, mcc_decode: purely combinational; maps (state, opcode, zero, sign) to the output control bus.
- The top level holds the state and halt flops, plus the optional counters.

Test Plan:
- RST=1 for 2 cycles, then release with opcode=add (000000) -> state sequence 000,001,110,111,000. ALUOp=000 and RegDst=10 in sWB_AL. RegWre=1 only in the 111 cycle.
- opcode=lw (100111) -> states IF,ID,010,011,100. mRD=1 only in 011. RegWre=1 and DBDataSrc=1 in 100. ALUOp=000, ALUSrcB=1, ExtSel=1.
- opcode=beq (110100), zero=1 in sEXE_BR -> PCSrc=01, PCWre=1. Repeat with zero=0 -> PCSrc=00. Repeat as bltz with sign=1 -> PCSrc=01.
- opcode=jal (111010) -> sID asserts PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0. Next state is sIF.
- opcode=halt (111111) -> after sID, PCWre/IRWre stay 0 for 20 cycles. RST=1 returns the unit to sIF.
- With MCC_PERF_CNT_EN: run add, lw, sw back-to-back -> inst_cnt=3, cyc_cnt=13. Assert RST mid-sw (in sEXE_LS) -> mWR never pulses and both counters read 0.
